mdu_hilo: RTL and testbench
===========================

Name: mdu_hilo

Overview:
Iterative multiply/divide unit with architectural HI/LO registers. It takes operands straight from the register file read ports (read_data1/read_data2) and produces the HI/LO values that MFHI/MFLO later route back to the register file write port. The control unit holds the PC on busy and uses the done pulse to retire the operation.

Parameters:
WIDTH, 32, operand/result width; iteration count equals WIDTH.

Ports:
inclk  input  1  clock, rising edge.
rstn  input  1  asynchronous, active-low reset.
start  input  1  request a new operation; sampled only in IDLE.
op  input  2  00 MULT (signed), 01 MULTU, 10 DIV (signed), 11 DIVU.
src_a  input  WIDTH  multiplicand / dividend (rs).
src_b  input  WIDTH  multiplier / divisor (rt).
hi_we  input  1  MTHI write enable.
lo_we  input  1  MTLO write enable.
wdata  input  WIDTH  MTHI/MTLO data.
busy  output  1  high while an operation is in flight.
done  output  1  one-cycle pulse; HI/LO hold the new result.
hi  output  WIDTH  HI register (product upper half / remainder).
lo  output  WIDTH  LO register (product lower half / quotient).

Behaviour:
- Reset (async, rstn=0): state=IDLE, busy=0, done=0, hi=0, lo=0, counter=0, internal datapath regs=0. Reset mid-operation aborts the operation with no HI/LO update.
- States: IDLE, RUN, FIX.
- IDLE, start=1 at edge E0:
  - Latch |src_a| and |src_b| (absolute value only for signed ops; unsigned ops latch raw values).
  - Latch sign flags and op.
  - Go to RUN, counter=0.
- RUN: one iteration per edge.
  - Multiply: shift-add, one multiplier bit per cycle.
  - Divide: restoring shift-subtract, one quotient bit per cycle.
  - After WIDTH iterations (edge E0+WIDTH), go to FIX.
- FIX, edge E0+WIDTH+1:
  - Apply sign correction:
    - MULT: negate the 2·WIDTH product if sign_a^sign_b.
    - DIV: quotient negated if sign_a^sign_b; remainder takes the sign of the dividend.
  - Write hi/lo, set done=1, return to IDLE.
- Latency: busy=1 during the cycles following edges E0..E0+WIDTH (WIDTH+1 cycles). done=1 for exactly the cycle after edge E0+WIDTH+1, while busy=0.
- start while busy: ignored; no queueing.
- start in the done cycle: accepted as a normal IDLE start.
- Divide by zero (src_b=0, DIV or DIVU): lo=all ones, hi=src_a (original, unsigned-raw value). Still takes full latency and pulses done.
- DIV -2^(WIDTH-1) / -1: lo=0x80000000, hi=0. No trap.
- hi_we/lo_we:
  - Honoured only in IDLE, with no start in the same cycle. Writes wdata at the edge; done not pulsed.
  - Ignored while busy or in FIX.
  - If start and a write are asserted together in IDLE, start wins and the write is dropped.
  - hi_we and lo_we together write both registers with wdata.
- hi/lo hold their value between updates. They are not disturbed by a running operation until FIX.
- Operand inputs are only sampled at start; they may change during RUN.

Test Plan:
- MULTU 7×6 -> after WIDTH+2 edges: done pulse, hi=0x00000000, lo=0x0000002A. busy high for exactly 33 cycles.
- MULT 0xFFFFFFFD (−3) × 5 -> hi=0xFFFFFFFF, lo=0xFFFFFFF1. MULTU 0xFFFFFFFF×0xFFFFFFFF -> hi=0xFFFFFFFE, lo=0x00000001.
- DIVU 100/7 -> lo=14, hi=2. DIV −7/2 -> lo=0xFFFFFFFD, hi=0xFFFFFFFF. DIV 0x80000000/0xFFFFFFFF -> lo=0x80000000, hi=0.
- DIVU 0x1234/0 -> lo=0xFFFFFFFF, hi=0x00001234, done after full latency.
- Busy and MT interactions:
  - MTLO 0xCAFEBABE in IDLE -> lo updates next edge.
  - Start MULTU, then assert lo_we and a second start during busy -> both ignored; result matches the first operation only.
  - start+hi_we in the same IDLE cycle -> hi unchanged until the result.
- Deassert rstn at iteration 10 of a DIV -> busy=0, done=0, hi=lo=0 immediately. A fresh MULTU 3×3 after release -> lo=9.

Source files
------------

// File: rtl/mdu_hilo.sv
// mdu_hilo: iterative multiply/divide unit with architectural HI/LO registers.
// Multiply is shift-add and divide is restoring shift-subtract, both on the
// operand magnitudes with one bit per cycle. Signs are applied in a final
// FIX cycle. MTHI/MTLO writes are accepted only while idle.
module mdu_hilo #(
    parameter int WIDTH = 32
) (
    input  logic             inclk,
    input  logic             rstn,
    input  logic             start,
    input  logic [1:0]       op,
    input  logic [WIDTH-1:0] src_a,
    input  logic [WIDTH-1:0] src_b,
    input  logic             hi_we,
    input  logic             lo_we,
    input  logic [WIDTH-1:0] wdata,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo
);

    localparam int CW = $clog2(WIDTH + 1);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_FIX  = 2'd2
    } state_t;

    state_t             r_state;
    state_t             w_state_next;
    logic [CW-1:0]      r_cnt;
    logic               r_is_div;
    logic               r_sign_a;
    logic               r_sign_b;
    logic               r_bzero;
    logic [WIDTH-1:0]   r_opnd;      // multiplicand (mul) or divisor (div) magnitude
    logic [WIDTH-1:0]   r_raw_a;     // original dividend, returned in HI on divide by zero
    logic [2*WIDTH:0]   r_acc;       // {upper partial, lower multiplier/quotient}
    logic [WIDTH-1:0]   r_hi;
    logic [WIDTH-1:0]   r_lo;
    logic               r_done;

    // Operand magnitudes: op[0]=1 selects the unsigned variants.
    logic               w_signed;
    logic               w_neg_a;
    logic               w_neg_b;
    logic [WIDTH-1:0]   w_abs_a;
    logic [WIDTH-1:0]   w_abs_b;

    assign w_signed = ~op[0];
    assign w_neg_a  = w_signed & src_a[WIDTH-1];
    assign w_neg_b  = w_signed & src_b[WIDTH-1];
    assign w_abs_a  = w_neg_a ? -src_a : src_a;
    assign w_abs_b  = w_neg_b ? -src_b : src_b;

    // Shift-add step: add multiplicand into the upper half when the current
    // multiplier bit is set, then shift the whole accumulator right.
    logic [WIDTH:0]     w_mul_sum;
    logic [WIDTH:0]     w_mul_upper;
    logic [2*WIDTH:0]   w_mul_next;

    assign w_mul_sum   = {1'b0, r_acc[2*WIDTH-1:WIDTH]} + {1'b0, r_opnd};
    assign w_mul_upper = r_acc[0] ? w_mul_sum : r_acc[2*WIDTH:WIDTH];
    assign w_mul_next  = {1'b0, w_mul_upper, r_acc[WIDTH-1:1]};

    // Restoring divide step: shift left, trial-subtract the divisor from the
    // upper part, keep the difference and set the quotient bit if no borrow.
    logic [2*WIDTH:0]   w_div_shift;
    logic [WIDTH+1:0]   w_div_diff;
    logic [2*WIDTH:0]   w_div_next;

    assign w_div_shift = {r_acc[2*WIDTH-1:0], 1'b0};
    assign w_div_diff  = {1'b0, w_div_shift[2*WIDTH:WIDTH]} - {2'b00, r_opnd};
    assign w_div_next  = w_div_diff[WIDTH+1] ? w_div_shift
                                             : {w_div_diff[WIDTH:0], w_div_shift[WIDTH-1:1], 1'b1};

    // Sign correction of the finished magnitudes.
    logic [2*WIDTH-1:0] w_prod;
    logic [2*WIDTH-1:0] w_prod_fix;
    logic [WIDTH-1:0]   w_quo;
    logic [WIDTH-1:0]   w_rem;
    logic [WIDTH-1:0]   w_quo_fix;
    logic [WIDTH-1:0]   w_rem_fix;
    logic [WIDTH-1:0]   w_res_hi;
    logic [WIDTH-1:0]   w_res_lo;

    assign w_prod     = r_acc[2*WIDTH-1:0];
    assign w_prod_fix = (r_sign_a ^ r_sign_b) ? -w_prod : w_prod;
    assign w_quo      = r_acc[WIDTH-1:0];
    assign w_rem      = r_acc[2*WIDTH-1:WIDTH];
    assign w_quo_fix  = (r_sign_a ^ r_sign_b) ? -w_quo : w_quo;
    assign w_rem_fix  = r_sign_a ? -w_rem : w_rem;

    assign w_res_hi = !r_is_div ? w_prod_fix[2*WIDTH-1:WIDTH] :
                      r_bzero   ? r_raw_a : w_rem_fix;
    assign w_res_lo = !r_is_div ? w_prod_fix[WIDTH-1:0] :
                      r_bzero   ? {WIDTH{1'b1}} : w_quo_fix;

    // State register.
    always_ff @(posedge inclk or negedge rstn) begin
        if (!rstn) r_state <= S_IDLE;
        else       r_state <= w_state_next;
    end

    // Next-state logic: IDLE -> RUN on start, RUN for WIDTH steps, one FIX cycle.
    always_comb begin
        w_state_next = r_state;
        case (r_state)
            S_IDLE:  if (start) w_state_next = S_RUN;
            S_RUN:   if (r_cnt == CW'(WIDTH - 1)) w_state_next = S_FIX;
            S_FIX:   w_state_next = S_IDLE;
            default: w_state_next = S_IDLE;
        endcase
    end

    // Datapath: operand latch, iteration, result write-back and MTHI/MTLO.
    always_ff @(posedge inclk or negedge rstn) begin
        if (!rstn) begin
            r_cnt    <= '0;
            r_is_div <= 1'b0;
            r_sign_a <= 1'b0;
            r_sign_b <= 1'b0;
            r_bzero  <= 1'b0;
            r_opnd   <= '0;
            r_raw_a  <= '0;
            r_acc    <= '0;
            r_hi     <= '0;
            r_lo     <= '0;
            r_done   <= 1'b0;
        end else begin
            r_done <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (start) begin
                        r_cnt    <= '0;
                        r_is_div <= op[1];
                        r_sign_a <= w_neg_a;
                        r_sign_b <= w_neg_b;
                        r_bzero  <= (src_b == '0);
                        r_raw_a  <= src_a;
                        r_opnd   <= op[1] ? w_abs_b : w_abs_a;
                        r_acc    <= {{(WIDTH+1){1'b0}}, (op[1] ? w_abs_a : w_abs_b)};
                    end else begin
                        if (hi_we) r_hi <= wdata;
                        if (lo_we) r_lo <= wdata;
                    end
                end
                S_RUN: begin
                    r_acc <= r_is_div ? w_div_next : w_mul_next;
                    r_cnt <= r_cnt + 1'b1;
                end
                S_FIX: begin
                    r_hi   <= w_res_hi;
                    r_lo   <= w_res_lo;
                    r_done <= 1'b1;
                end
                default: ;
            endcase
        end
    end

    assign busy = (r_state != S_IDLE);
    assign done = r_done;
    assign hi   = r_hi;
    assign lo   = r_lo;

endmodule

// File: tb/tb_mdu_hilo.sv
// tb_mdu_hilo: table-driven checks of mdu_hilo plus hand sequences for
// MTHI/MTLO interaction, back-to-back start and mid-operation reset.
module tb_mdu_hilo;

    logic        inclk;
    logic        rstn;
    logic        start;
    logic [1:0]  op;
    logic [31:0] src_a;
    logic [31:0] src_b;
    logic        hi_we;
    logic        lo_we;
    logic [31:0] wdata;
    logic        busy;
    logic        done;
    logic [31:0] hi;
    logic [31:0] lo;

    int total = 0;
    int bad   = 0;

    mdu_hilo #(.WIDTH(32)) dut (
        .inclk (inclk),
        .rstn  (rstn),
        .start (start),
        .op    (op),
        .src_a (src_a),
        .src_b (src_b),
        .hi_we (hi_we),
        .lo_we (lo_we),
        .wdata (wdata),
        .busy  (busy),
        .done  (done),
        .hi    (hi),
        .lo    (lo)
    );

    initial inclk = 1'b0;
    always #5 inclk = ~inclk;

    typedef struct {
        string       name;
        logic [1:0]  op;
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] exp_hi;
        logic [31:0] exp_lo;
    } vec_t;

    localparam logic [1:0] OP_MULT = 2'b00, OP_MULTU = 2'b01, OP_DIV = 2'b10, OP_DIVU = 2'b11;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Called at the negedge following the start edge; returns at the negedge
    // of the done cycle (or after the cycle budget runs out).
    task automatic wait_done(output int busy_cycles, output bit got_done);
        busy_cycles = 0;
        got_done    = 1'b0;
        for (int i = 0; i < 100; i++) begin
            if (done) begin
                got_done = 1'b1;
                break;
            end
            if (busy) busy_cycles++;
            @(negedge inclk);
        end
    endtask

    task automatic pulse_start(input logic [1:0] o, input logic [31:0] a, input logic [31:0] b);
        @(negedge inclk);
        start = 1'b1; op = o; src_a = a; src_b = b;
        @(negedge inclk);
        start = 1'b0;
    endtask

    vec_t vecs[10];
    int   bc;
    bit   gd;

    initial begin
        rstn = 1'b0; start = 1'b0; op = 2'b00; src_a = '0; src_b = '0;
        hi_we = 1'b0; lo_we = 1'b0; wdata = '0;

        vecs[0] = '{"multu_7x6",      OP_MULTU, 32'd7,        32'd6,        32'h00000000, 32'h0000002A};
        vecs[1] = '{"mult_m3x5",      OP_MULT,  32'hFFFFFFFD, 32'd5,        32'hFFFFFFFF, 32'hFFFFFFF1};
        vecs[2] = '{"multu_max_sq",   OP_MULTU, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, 32'h00000001};
        vecs[3] = '{"mult_min_sq",    OP_MULT,  32'h80000000, 32'h80000000, 32'h40000000, 32'h00000000};
        vecs[4] = '{"divu_100_7",     OP_DIVU,  32'd100,      32'd7,        32'd2,        32'd14};
        vecs[5] = '{"div_m7_2",       OP_DIV,   32'hFFFFFFF9, 32'd2,        32'hFFFFFFFF, 32'hFFFFFFFD};
        vecs[6] = '{"div_7_m2",       OP_DIV,   32'd7,        32'hFFFFFFFE, 32'd1,        32'hFFFFFFFD};
        vecs[7] = '{"div_min_m1",     OP_DIV,   32'h80000000, 32'hFFFFFFFF, 32'h00000000, 32'h80000000};
        vecs[8] = '{"divu_by_zero",   OP_DIVU,  32'h00001234, 32'd0,        32'h00001234, 32'hFFFFFFFF};
        vecs[9] = '{"div_m7_by_zero", OP_DIV,   32'hFFFFFFF9, 32'd0,        32'hFFFFFFF9, 32'hFFFFFFFF};

        // Reset state
        repeat (3) @(negedge inclk);
        check("reset_busy", {31'd0, busy}, 32'd0);
        check("reset_done", {31'd0, done}, 32'd0);
        check("reset_hi", hi, 32'd0);
        check("reset_lo", lo, 32'd0);
        rstn = 1'b1;

        // Table-driven operations
        for (int i = 0; i < 10; i++) begin
            pulse_start(vecs[i].op, vecs[i].a, vecs[i].b);
            wait_done(bc, gd);
            check({vecs[i].name, "_done"}, {31'd0, gd}, 32'd1);
            check({vecs[i].name, "_busy_cycles"}, bc, 32'd33);
            check({vecs[i].name, "_busy_at_done"}, {31'd0, busy}, 32'd0);
            check({vecs[i].name, "_hi"}, hi, vecs[i].exp_hi);
            check({vecs[i].name, "_lo"}, lo, vecs[i].exp_lo);
            @(negedge inclk);
            check({vecs[i].name, "_done_one_cycle"}, {31'd0, done}, 32'd0);
            $display("op %0d a=%h b=%h -> hi=%h lo=%h (%s)", vecs[i].op, vecs[i].a, vecs[i].b, hi, lo, vecs[i].name);
        end

        // MTLO in idle, then MTHI+MTLO together
        @(negedge inclk);
        lo_we = 1'b1; wdata = 32'hCAFEBABE;
        @(negedge inclk);
        lo_we = 1'b0;
        check("mtlo_lo", lo, 32'hCAFEBABE);
        check("mtlo_hi_kept", hi, 32'hFFFFFFF9);
        check("mtlo_no_done", {31'd0, done}, 32'd0);
        hi_we = 1'b1; lo_we = 1'b1; wdata = 32'h11112222;
        @(negedge inclk);
        hi_we = 1'b0; lo_we = 1'b0;
        check("mthilo_hi", hi, 32'h11112222);
        check("mthilo_lo", lo, 32'h11112222);
        $display("mt writes: hi=%h lo=%h", hi, lo);

        // Writes and a second start while busy are ignored
        pulse_start(OP_MULTU, 32'd3, 32'd5);
        @(negedge inclk);
        start = 1'b1; op = OP_DIVU; src_a = 32'd99; src_b = 32'd4;
        lo_we = 1'b1; hi_we = 1'b1; wdata = 32'hDEADBEEF;
        repeat (3) @(negedge inclk);
        start = 1'b0; lo_we = 1'b0; hi_we = 1'b0;
        check("busy_lo_held", lo, 32'h11112222);
        check("busy_hi_held", hi, 32'h11112222);
        wait_done(bc, gd);
        check("busy_ign_done", {31'd0, gd}, 32'd1);
        check("busy_ign_hi", hi, 32'd0);
        check("busy_ign_lo", lo, 32'd15);
        $display("busy ignore: hi=%h lo=%h", hi, lo);

        // start + hi_we in the same idle cycle: start wins
        @(negedge inclk);
        hi_we = 1'b1; wdata = 32'h5555AAAA;
        @(negedge inclk);
        hi_we = 1'b1; wdata = 32'h12345678;
        start = 1'b1; op = OP_MULTU; src_a = 32'd2; src_b = 32'd2;
        @(negedge inclk);
        start = 1'b0; hi_we = 1'b0;
        check("start_we_busy", {31'd0, busy}, 32'd1);
        check("start_we_hi_kept", hi, 32'h5555AAAA);
        wait_done(bc, gd);
        check("start_we_hi", hi, 32'd0);
        check("start_we_lo", lo, 32'd4);
        $display("start+hi_we: hi=%h lo=%h", hi, lo);

        // Start accepted in the done cycle
        start = 1'b1; op = OP_DIVU; src_a = 32'd50; src_b = 32'd8;
        @(negedge inclk);
        start = 1'b0;
        check("b2b_busy", {31'd0, busy}, 32'd1);
        wait_done(bc, gd);
        check("b2b_cycles", bc, 32'd33);
        check("b2b_hi", hi, 32'd2);
        check("b2b_lo", lo, 32'd6);
        $display("back-to-back divu 50/8: hi=%h lo=%h", hi, lo);

        // Reset in the middle of a DIV
        @(negedge inclk);
        pulse_start(OP_DIV, 32'd1000, 32'd3);
        repeat (10) @(negedge inclk);
        rstn = 1'b0;
        #1;
        check("midrst_busy", {31'd0, busy}, 32'd0);
        check("midrst_done", {31'd0, done}, 32'd0);
        check("midrst_hi", hi, 32'd0);
        check("midrst_lo", lo, 32'd0);
        @(negedge inclk);
        rstn = 1'b1;
        pulse_start(OP_MULTU, 32'd3, 32'd3);
        wait_done(bc, gd);
        check("post_rst_done", {31'd0, gd}, 32'd1);
        check("post_rst_hi", hi, 32'd0);
        check("post_rst_lo", lo, 32'd9);
        $display("after reset multu 3x3: hi=%h lo=%h", hi, lo);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
